// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: rotating-priority selection among functional-unit
// result requests, with a registered broadcast stage, stall hold and statistics.
module cdb_arbiter #(
    parameter int NREQ      = 4,
    parameter int UNIT_SIZE = 8,
    parameter int WORD_SIZE = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*UNIT_SIZE-1:0] req_tag,
    input  logic [NREQ*WORD_SIZE-1:0] req_data,
    output logic [NREQ-1:0]           req_grant,
    input  logic                      cdb_stall,
    output logic                      cdb_valid,
    output logic [UNIT_SIZE-1:0]      cdb_tag,
    output logic [WORD_SIZE-1:0]      cdb_data,
    output logic                      tag_err,
    output logic [15:0]               bcast_cnt,
    output logic                      idle
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [UNIT_SIZE-1:0] RESERVED_TAG = UNIT_SIZE'(8'h7F);

    logic                 r_valid;
    logic [UNIT_SIZE-1:0] r_tag;
    logic [WORD_SIZE-1:0] r_data;
    logic [PTR_W-1:0]     r_ptr;
    logic                 r_tag_err;
    logic [15:0]          r_cnt;

    logic [UNIT_SIZE-1:0] w_tag  [NREQ];
    logic [WORD_SIZE-1:0] w_data [NREQ];
    logic [NREQ-1:0]      w_grant;
    logic [PTR_W-1:0]     w_idx;
    logic [PTR_W-1:0]     w_ptr_next;
    logic                 w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_tag[gi]  = req_tag[gi*UNIT_SIZE +: UNIT_SIZE];
            assign w_data[gi] = req_data[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        int c;
        c       = 0;
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (rst_n && !cdb_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                c = int'(r_ptr) + k;
                if (c >= NREQ) begin
                    c = c - NREQ;
                end
                if (!w_found && req_valid[PTR_W'(c)]) begin
                    w_found = 1'b1;
                    w_idx   = PTR_W'(c);
                end
            end
        end
        if (w_found) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    assign w_ptr_next = (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_tag     <= '0;
            r_data    <= '0;
            r_ptr     <= '0;
            r_tag_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (r_valid && !cdb_stall) begin
                r_cnt <= r_cnt + 16'd1;
            end
            // Under stall the whole bus stage, pointer included, is frozen.
            if (!cdb_stall) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_tag   <= w_tag[w_idx];
                    r_data  <= w_data[w_idx];
                    r_ptr   <= w_ptr_next;
                    if (w_tag[w_idx] == RESERVED_TAG) begin
                        r_tag_err <= 1'b1;
                    end
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign req_grant = w_grant;
    assign cdb_valid = r_valid;
    assign cdb_tag   = r_tag;
    assign cdb_data  = r_data;
    assign tag_err   = r_tag_err;
    assign bcast_cnt = r_cnt;
    assign idle      = (req_valid == '0) && !r_valid;

endmodule
